// File: rtl/matmul_seq_pkg.sv
// Shared types and widths for the matrix-multiplier stream sequencer.
package matmul_seq_pkg;

    localparam int DATA_W = 32;
    localparam int WCNT_W = 9;
    localparam int CNT_W  = 20;

    typedef enum logic [2:0] {
        HOLDOFF,
        SEND_A,
        SEND_B,
        WAIT_OUT,
        DONE_RUN,
        FINISHED
    } seq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Counts AXI-stream handshake beats with a synchronous clear and a
// terminal-count flag that fires on the beat that reaches term.
module axis_beat_counter
    import matmul_seq_pkg::*;
#(
    parameter int W = WCNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         beat,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         at_term
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (beat && !(&count)) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = beat && (count == term - 1'b1);

endmodule

// File: rtl/matmul_stream_sequencer.sv
// Drives A then B into the HLS multiplier, watches the result stream,
// and reports run count, latency and protocol errors.
module matmul_stream_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int unsigned MAT_DIM        = 4,
    parameter int unsigned START_DELAY    = 20000,
    parameter int unsigned NUM_RUNS       = 8,
    parameter logic [31:0] A_VALUE        = 32'd3,
    parameter logic [31:0] B_VALUE        = 32'd14,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [DATA_W-1:0] input_r_TDATA_0,
    output logic              input_r_TVALID_0,
    output logic              input_r_TLAST_0,
    input  logic              input_r_TREADY_0,
    input  logic              output_r_TVALID_0,
    input  logic              output_r_TREADY_0,
    input  logic              output_r_TLAST_0,
    output logic              busy,
    output logic [7:0]        run_count,
    output logic [CNT_W-1:0]  last_latency,
    output logic              tlast_err,
    output logic              timeout_err
);

    localparam logic [WCNT_W-1:0] WORDS =
        WCNT_W'(MAT_DIM * MAT_DIM);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (START_DELAY == 0) ? '0 : CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        state;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  lat_cnt;
    logic [WCNT_W-1:0] in_cnt;
    logic [WCNT_W-1:0] out_cnt;
    logic              in_beat;
    logic              out_beat;
    logic              in_last;
    logic              out_last;
    logic              out_over;
    logic              in_clear;
    logic              out_clear;
    logic              hold_done;
    logic              runs_done;
    logic              lat_first;
    logic              out_good;
    logic              out_bad;
    logic              tmo_hit;
    logic [7:0]        next_runs;

    assign in_beat   = input_r_TVALID_0 && input_r_TREADY_0;
    assign out_beat  = output_r_TVALID_0 && output_r_TREADY_0;
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign next_runs = (&run_count) ? run_count : run_count + 8'd1;
    assign runs_done = (NUM_RUNS != 0) &&
                       (32'(next_runs) == NUM_RUNS);

    // Result beats are attributed to the run that is about to start.
    assign out_clear = (state == HOLDOFF && hold_done) ||
                       (state == DONE_RUN && !runs_done);
    assign in_clear  = (state == SEND_A || state == SEND_B) &&
                       in_last;
    assign lat_first = (state == SEND_A) && in_beat &&
                       (in_cnt == '0);

    assign out_over = out_beat && (out_cnt >= WORDS);
    assign out_good = out_last && output_r_TLAST_0;
    assign out_bad  = out_beat &&
                      (output_r_TLAST_0 ? !out_last
                                        : (out_last || out_over));
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    axis_beat_counter #(.W(WCNT_W)) u_in_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (in_clear),
        .beat    (in_beat),
        .term    (WORDS),
        .count   (in_cnt),
        .at_term (in_last)
    );

    axis_beat_counter #(.W(WCNT_W)) u_out_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (out_clear),
        .beat    (out_beat),
        .term    (WORDS),
        .count   (out_cnt),
        .at_term (out_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= HOLDOFF;
            hold_cnt         <= '0;
            tmo_cnt          <= '0;
            lat_cnt          <= '0;
            input_r_TDATA_0  <= '0;
            input_r_TVALID_0 <= 1'b0;
            input_r_TLAST_0  <= 1'b0;
            busy             <= 1'b0;
            run_count        <= '0;
            last_latency     <= '0;
            tlast_err        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            lat_cnt <= lat_first ? '0 : sat_inc(lat_cnt);
            unique case (state)
                HOLDOFF: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_done) begin
                        state            <= SEND_A;
                        input_r_TVALID_0 <= 1'b1;
                        input_r_TDATA_0  <= A_VALUE;
                        busy             <= 1'b1;
                    end
                end
                SEND_A: begin
                    if (in_last) begin
                        state           <= SEND_B;
                        input_r_TDATA_0 <= B_VALUE;
                        input_r_TLAST_0 <= (WORDS == WCNT_W'(1));
                    end
                end
                SEND_B: begin
                    if (in_last) begin
                        state            <= WAIT_OUT;
                        input_r_TVALID_0 <= 1'b0;
                        input_r_TLAST_0  <= 1'b0;
                        input_r_TDATA_0  <= '0;
                        tmo_cnt          <= '0;
                    end else if (in_beat) begin
                        input_r_TLAST_0 <=
                            (10'(in_cnt) + 10'd2 == 10'(WORDS));
                    end
                end
                WAIT_OUT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (out_good) begin
                        state        <= DONE_RUN;
                        last_latency <= sat_inc(lat_cnt);
                    end else if (out_bad) begin
                        state     <= DONE_RUN;
                        tlast_err <= 1'b1;
                    end else if (tmo_hit) begin
                        state       <= DONE_RUN;
                        timeout_err <= 1'b1;
                    end
                end
                DONE_RUN: begin
                    run_count <= next_runs;
                    if (runs_done) begin
                        state <= FINISHED;
                        busy  <= 1'b0;
                    end else begin
                        state            <= SEND_A;
                        input_r_TVALID_0 <= 1'b1;
                        input_r_TDATA_0  <= A_VALUE;
                    end
                end
                FINISHED: begin
                    state <= FINISHED;
                end
                default: begin
                    state <= HOLDOFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream_sequencer.sv
// Directed-random bench for matmul_stream_sequencer with a queue-based
// model of the expected input stream, run latency and run outcomes.
module tb_matmul_stream_sequencer;

    localparam int N    = 2;
    localparam int NN   = N * N;
    localparam int SD   = 10;
    localparam int RUNS = 3;
    localparam int TMO  = 50;
    localparam logic [31:0] AV = 32'd3;
    localparam logic [31:0] BV = 32'd14;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] input_r_TDATA_0;
    logic        input_r_TVALID_0;
    logic        input_r_TLAST_0;
    logic        input_r_TREADY_0;
    logic        output_r_TVALID_0;
    logic        output_r_TREADY_0;
    logic        output_r_TLAST_0;
    logic        busy;
    logic [7:0]  run_count;
    logic [19:0] last_latency;
    logic        tlast_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    matmul_stream_sequencer #(
        .MAT_DIM        (N),
        .START_DELAY    (SD),
        .NUM_RUNS       (RUNS),
        .A_VALUE        (AV),
        .B_VALUE        (BV),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .input_r_TDATA_0   (input_r_TDATA_0),
        .input_r_TVALID_0  (input_r_TVALID_0),
        .input_r_TLAST_0   (input_r_TLAST_0),
        .input_r_TREADY_0  (input_r_TREADY_0),
        .output_r_TVALID_0 (output_r_TVALID_0),
        .output_r_TREADY_0 (output_r_TREADY_0),
        .output_r_TLAST_0  (output_r_TLAST_0),
        .busy              (busy),
        .run_count         (run_count),
        .last_latency      (last_latency),
        .tlast_err         (tlast_err),
        .timeout_err       (timeout_err)
    );

    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          t1 = 0;
    int          lat_exp = 0;
    int          tmo_k = 0;
    logic        stalled = 1'b0;
    logic [31:0] st_data = '0;
    logic        st_last = 1'b0;
    logic [32:0] in_q[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic ov,
                        input logic ordy, input logic ol);
        input_r_TREADY_0  = rdy;
        output_r_TVALID_0 = ov;
        output_r_TREADY_0 = ordy;
        output_r_TLAST_0  = ol;
        if (stalled) begin
            check("stall_valid", input_r_TVALID_0, 1);
            check("stall_data", input_r_TDATA_0, st_data);
            check("stall_last", input_r_TLAST_0, st_last);
        end
        stalled = reset_n && input_r_TVALID_0 && !rdy;
        st_data = input_r_TDATA_0;
        st_last = input_r_TLAST_0;
        if (reset_n && input_r_TVALID_0 && rdy) begin
            if (in_q.size() == 0) t0 = cyc;
            in_q.push_back({input_r_TLAST_0, input_r_TDATA_0});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic hold_off();
        int   n;
        logic pb;
        n  = 0;
        pb = 1'b0;
        while (input_r_TVALID_0 !== 1'b1 && n < 100) begin
            pb = busy;
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("holdoff_cycles", n, SD);
        check("busy_rise", {pb, busy}, 2'b01);
    endtask

    task automatic feed(input bit toggle, input int upto);
        int k;
        k = 0;
        in_q.delete();
        while (in_q.size() < upto && k < 200) begin
            step(toggle ? ((k % 2) == 0) : 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("feed_done", in_q.size(), upto);
    endtask

    task automatic check_stream();
        for (int i = 0; i < 2 * NN; i++) begin
            if (i < in_q.size()) begin
                check($sformatf("beat%0d_data", i), in_q[i][31:0],
                      (i < NN) ? AV : BV);
                check($sformatf("beat%0d_last", i), in_q[i][32],
                      (i == 2 * NN - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic result_phase(input int tl_pos);
        logic [7:0] rc0;
        int         ob;
        int         k;
        bit         sent;
        logic       ov;
        logic       ordy;
        logic       ol;
        rc0   = run_count;
        ob    = 0;
        k     = 0;
        sent  = 0;
        tmo_k = -1;
        while (run_count === rc0 && k < 300) begin
            ov   = (tl_pos != 0) && !sent && ($urandom_range(0, 1) == 1);
            ordy = 1'($urandom_range(0, 1));
            ol   = ov && (ob + 1 == tl_pos);
            if (ov && ordy) begin
                ob++;
                if (ol) begin
                    sent = 1;
                    t1   = cyc;
                end
            end
            step(1'b0, ov, ordy, ol);
            k++;
            if (tmo_k < 0 && timeout_err === 1'b1) tmo_k = k;
        end
        check("run_done", {63'd0, run_count !== rc0}, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        input_r_TREADY_0  = 1'b0;
        output_r_TVALID_0 = 1'b0;
        output_r_TREADY_0 = 1'b0;
        output_r_TLAST_0  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", input_r_TVALID_0, 0);
        check("rst_tlast", input_r_TLAST_0, 0);
        check("rst_tdata", input_r_TDATA_0, 0);
        check("rst_busy", busy, 0);
        check("rst_runs", run_count, 0);
        check("rst_latency", last_latency, 0);
        check("rst_tlast_err", tlast_err, 0);
        check("rst_timeout_err", timeout_err, 0);

        reset_n = 1'b1;
        hold_off();

        feed(1'b1, 2 * NN);
        check_stream();
        result_phase(NN);
        lat_exp = t1 - t0;
        check("r1_latency", last_latency, lat_exp);
        check("r1_runs", run_count, 1);
        check("r1_tlast_err", tlast_err, 0);
        check("r1_timeout_err", timeout_err, 0);
        check("r1_next_start", input_r_TVALID_0, 1);

        feed(1'b0, 2 * NN);
        check_stream();
        result_phase(2);
        check("early_tlast_err", tlast_err, 1);
        check("early_runs", run_count, 2);
        check("early_next_start", input_r_TVALID_0, 1);
        check("early_busy", busy, 1);

        feed(1'b0, NN + 1);
        reset_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_tvalid", input_r_TVALID_0, 0);
        check("mid_rst_tlast", input_r_TLAST_0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_runs", run_count, 0);
        check("mid_rst_tlast_err", tlast_err, 0);
        check("mid_rst_latency", last_latency, 0);
        reset_n = 1'b1;
        hold_off();

        feed(1'b0, 2 * NN);
        check_stream();
        result_phase(NN);
        lat_exp = t1 - t0;
        check("p2r1_latency", last_latency, lat_exp);
        check("p2r1_runs", run_count, 1);

        feed(1'b0, 2 * NN);
        result_phase(0);
        check("tmo_cycles", tmo_k, TMO);
        check("tmo_flag", timeout_err, 1);
        check("tmo_latency_kept", last_latency, lat_exp);
        check("tmo_runs", run_count, 2);
        check("tmo_tlast_err", tlast_err, 0);

        feed(1'b0, 2 * NN);
        check_stream();
        result_phase(NN);
        lat_exp = t1 - t0;
        check("fin_latency", last_latency, lat_exp);
        check("fin_runs", run_count, RUNS);
        check("fin_busy", busy, 0);
        check("fin_tvalid", input_r_TVALID_0, 0);

        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_tvalid", input_r_TVALID_0, 0);
        check("idle_busy", busy, 0);
        check("idle_runs", run_count, RUNS);
        check("idle_timeout_err", timeout_err, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matmul_stream_sequencer.md
Name: matmul_stream_sequencer

Overview:
- Sequences the HLS matrix multiplier from the fabric side.
- After a power-up hold-off it runs NUM_RUNS iterations. Each run streams matrix A and then matrix B on the multiplier's input AXI-stream. It then monitors the multiplier's output stream until the result matrix completes or a timeout expires.
- It reports run count, per-run latency and protocol errors.
- It sits beside the output-stream checker: the sequencer drives the input side, the checker consumes the output side.

Parameters:
- MAT_DIM, 4, matrix dimension N; each matrix is N*N 32-bit words (legal 1..16).
- START_DELAY, 20000, cycles after reset before the first run starts (20-bit).
- NUM_RUNS, 8, number of runs; 0 means run forever.
- A_VALUE, 32'd3, constant data word for every element of A.
- B_VALUE, 32'd14, constant data word for every element of B. With N=1 the result element is 42.
- TIMEOUT_CYCLES, 4096, maximum cycles in WAIT_OUT before the run is abandoned (20-bit).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous reset, active-low.
- input_r_TDATA_0  output  32  stream data to multiplier.
- input_r_TVALID_0  output  1  stream valid.
- input_r_TLAST_0  output  1  high on final word of B only.
- input_r_TREADY_0  input  1  multiplier ready.
- output_r_TVALID_0  input  1  monitored result valid.
- output_r_TREADY_0  input  1  monitored result ready (driven by checker).
- output_r_TLAST_0  input  1  monitored result last.
- busy  output  1  high in any state except HOLDOFF and FINISHED.
- run_count  output  8  completed runs, saturating at 255.
- last_latency  output  20  cycles from first accepted A word to accepted result TLAST.
- tlast_err  output  1  sticky flag: TLAST position wrong.
- timeout_err  output  1  sticky flag: a run timed out.

Behaviour:
- Reset (reset_n=0 at posedge): state=HOLDOFF; all counters=0; TVALID=0, TLAST=0, TDATA=0; busy=0, run_count=0, last_latency=0, both error flags=0.
- Reset is honoured mid-run. The stream drops TVALID the same edge; no handshake completes during reset.
- An input beat transfers when TVALID & TREADY at a posedge. An output beat is counted when output_r_TVALID_0 & output_r_TREADY_0.
- All outputs are registered.
- HOLDOFF: a 20-bit counter increments each cycle. When the counter equals START_DELAY-1 → SEND_A. START_DELAY=0 goes to SEND_A on the first cycle after reset.
- SEND_A: TVALID=1, TDATA=A_VALUE. The word counter counts accepted beats. After the N*N-th acceptance → SEND_B, counter cleared, and the next word is presented immediately with no bubble.
- SEND_B: TVALID=1, TDATA=B_VALUE. TLAST=1 only while presenting word N*N-1. On its acceptance → WAIT_OUT, TVALID=0 the following cycle.
- TVALID and TDATA hold stable while TREADY=0 (AXI rule). TVALID never deasserts before acceptance.
- Latency counter: cleared and started on the first accepted A beat. It saturates at 2^20-1.
- WAIT_OUT:
  - The output-beat counter counts result beats and the timeout counter increments each cycle.
  - TLAST on beat N*N → DONE_RUN, last_latency loaded.
  - TLAST on any other beat, or beat N*N without TLAST: tlast_err set and the state goes to DONE_RUN immediately.
  - Timeout counter reaching TIMEOUT_CYCLES → timeout_err set, DONE_RUN, last_latency unchanged.
  - Beat completion and timeout on the same cycle: the beat wins.
- Output beats seen outside WAIT_OUT (early results) are counted toward the current run's output count. The output counter clears only on entry to SEND_A.
- DONE_RUN (1 cycle): run_count increments.
  - If NUM_RUNS≠0 and the incremented count equals NUM_RUNS → FINISHED; otherwise → SEND_A.
  - There is no hold-off between runs.
- FINISHED: idle until reset; busy=0, run_count held.
- Width rules: word counters are 9 bits (max 256). All counter comparisons are unsigned.

Decomposition:
- Package matmul_seq_pkg holds the state encoding (HOLDOFF, SEND_A, SEND_B, WAIT_OUT, DONE_RUN, FINISHED), the stream width constant 32 and the counter width constants 9/20.
- One sub-module, axis_beat_counter: counts handshake beats with clear and a terminal-count compare. It is instantiated for the input and output word counts.

Test Plan:
- Reset/hold-off: START_DELAY=10, TREADY=1 → TVALID first high 10 cycles after reset_n rises; busy rises the same cycle.
- Back-pressure: N=2, TREADY toggled 1/0 each cycle → exactly 4 beats of 3 then 4 beats of 14; TDATA/TVALID stable while stalled; TLAST only on the 8th beat.
- Good run: N=2, NUM_RUNS=2, result model returns 4 beats with TLAST on the 4th → run_count 1 then 2, FINISHED, busy=0, no error flags, last_latency equals the measured cycles.
- Early TLAST: result TLAST on beat 2 of 4 → tlast_err=1, run_count increments, next run starts.
- Timeout: TIMEOUT_CYCLES=50, no result beats → timeout_err=1 after 50 WAIT_OUT cycles, last_latency unchanged.
- Mid-run reset: reset_n low during SEND_B → next posedge TVALID=0, run_count=0, flags=0, hold-off restarts.
